prbs_lock_check: RTL and testbench

Parametrised PRBS receive checker for the PCS user-side AXIS RX stream: the next generation of the fixed-pattern checker. It supports a runtime-selectable polynomial (PRBS7/15/23/31) and a configurable datapath width. A SEARCH/LOCKED state machine self-synchronises to the incoming pattern, then counts bit errors with saturating counters. It sits on the `rx_user_clk` domain directly after the PCS RX AXIS output.

---
 rtl/prbs_pkg.sv | 37 +++
 rtl/prbs_predict.sv | 40 ++++
 rtl/prbs_lock_check.sv | 160 ++++++++++++++++
 tb/tb_prbs_lock_check.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial selection, tap pairs and checker states.
// Also imported by the companion PRBS generator.
package prbs_pkg;

  localparam int HIST_W = 31;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_sel_t;

  typedef enum logic [1:0] {
    SEARCH_SEED = 2'd0,
    SEARCH      = 2'd1,
    LOCKED      = 2'd2
  } chk_state_t;

  // Bit n = b[n-N] ^ b[n-M]
  typedef struct packed {
    logic [4:0] n;
    logic [4:0] m;
  } prbs_taps_t;

  function automatic prbs_taps_t prbs_taps(input prbs_sel_t sel);
    prbs_taps_t t;
    case (sel)
      PRBS7:   begin t.n = 5'd7;  t.m = 5'd6;  end
      PRBS15:  begin t.n = 5'd15; t.m = 5'd14; end
      PRBS23:  begin t.n = 5'd23; t.m = 5'd18; end
      default: begin t.n = 5'd31; t.m = 5'd28; end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational word-wide PRBS predictor: extends a 31-bit history by DATA_W
// bits, feeding back either the source bits or its own predictions.
module prbs_predict
  import prbs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [HIST_W-1:0] hist_i,
  input  prbs_sel_t         sel_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic              self_run_i,
  output logic [DATA_W-1:0] pred_o,
  output logic [HIST_W-1:0] hist_next_o
);

  localparam prbs_taps_t T7  = prbs_taps(PRBS7);
  localparam prbs_taps_t T15 = prbs_taps(PRBS15);
  localparam prbs_taps_t T23 = prbs_taps(PRBS23);
  localparam prbs_taps_t T31 = prbs_taps(PRBS31);

  // seq[HIST_W-1] is the newest history bit; word bit i lands at HIST_W+i.
  logic [HIST_W+DATA_W-1:0] seq;

  always_comb begin
    seq               = '0;
    seq[HIST_W-1:0]   = hist_i;
    pred_o            = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (sel_i)
        PRBS7:   pred_o[i] = seq[HIST_W+i-int'(T7.n)]  ^ seq[HIST_W+i-int'(T7.m)];
        PRBS15:  pred_o[i] = seq[HIST_W+i-int'(T15.n)] ^ seq[HIST_W+i-int'(T15.m)];
        PRBS23:  pred_o[i] = seq[HIST_W+i-int'(T23.n)] ^ seq[HIST_W+i-int'(T23.m)];
        default: pred_o[i] = seq[HIST_W+i-int'(T31.n)] ^ seq[HIST_W+i-int'(T31.m)];
      endcase
      seq[HIST_W+i] = self_run_i ? pred_o[i] : src_i[i];
    end
    hist_next_o = seq[HIST_W+DATA_W-1 -: HIST_W];
  end

endmodule

// File: rtl/prbs_lock_check.sv
// Self-synchronising PRBS7/15/23/31 receive checker with saturating error counters.
// Optional PRBS_LOCK_CHECK_INV_EN adds inv_i to check polarity-swapped lanes.
module prbs_lock_check
  import prbs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 8,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                 rx_user_clk_i,
  input  logic                 rx_user_rst_i,
  input  logic [DATA_W-1:0]    rx_data_i,
  input  logic                 rx_valid_i,
  input  logic [1:0]           prbs_sel_i,
  input  logic                 clr_i,
`ifdef PRBS_LOCK_CHECK_INV_EN
  input  logic                 inv_i,
`endif
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic [ERR_CNT_W-1:0] bit_err_cnt_o,
  output logic [ERR_CNT_W-1:0] word_cnt_o
);

  localparam int POP_W  = $clog2(DATA_W + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int SUM_W  = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  chk_state_t           state_reg;
  prbs_sel_t            sel_reg;
  logic [HIST_W-1:0]    hist_reg;
  logic [GOOD_W-1:0]    good_cnt_reg;
  logic [BAD_W-1:0]     bad_cnt_reg;
  logic                 locked_reg;
  logic                 err_pulse_reg;
  logic [ERR_CNT_W-1:0] bit_err_reg;
  logic [ERR_CNT_W-1:0] word_cnt_reg;

  logic [DATA_W-1:0]    data_chk;
  logic [DATA_W-1:0]    pred;
  logic [DATA_W-1:0]    err_vec;
  logic [HIST_W-1:0]    hist_next;
  logic [POP_W-1:0]     err_pop;
  logic                 err_any;
  logic                 sel_change;
  logic [SUM_W-1:0]     bit_err_sum;
  logic [ERR_CNT_W-1:0] bit_err_next;
  logic [ERR_CNT_W-1:0] word_cnt_next;

`ifdef PRBS_LOCK_CHECK_INV_EN
  assign data_chk = rx_data_i ^ {DATA_W{inv_i}};
`else
  assign data_chk = rx_data_i;
`endif

  // Locked predictions free-run so a received error never corrupts later words.
  prbs_predict #(
    .DATA_W(DATA_W)
  ) u_predict (
    .hist_i      (hist_reg),
    .sel_i       (sel_reg),
    .src_i       (data_chk),
    .self_run_i  (state_reg == LOCKED),
    .pred_o      (pred),
    .hist_next_o (hist_next)
  );

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_err
      assign err_vec[gi] = pred[gi] ^ data_chk[gi];
    end
  endgenerate

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      err_pop = err_pop + POP_W'(err_vec[i]);
    end
  end

  assign err_any    = |err_vec;
  assign sel_change = (prbs_sel_t'(prbs_sel_i) != sel_reg);

  // Sum is wide enough for both operands so a large popcount clamps instead of wrapping.
  assign bit_err_sum   = SUM_W'(bit_err_reg) + SUM_W'(err_pop);
  assign bit_err_next  = (bit_err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_err_sum[ERR_CNT_W-1:0];
  assign word_cnt_next = (word_cnt_reg == CNT_MAX) ? CNT_MAX : word_cnt_reg + ERR_CNT_W'(1);

  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      state_reg     <= SEARCH_SEED;
      sel_reg       <= PRBS7;
      hist_reg      <= '0;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      bit_err_reg   <= '0;
      word_cnt_reg  <= '0;
    end else begin
      sel_reg       <= prbs_sel_t'(prbs_sel_i);
      err_pulse_reg <= 1'b0;
      if (sel_change) begin
        state_reg    <= SEARCH_SEED;
        locked_reg   <= 1'b0;
        good_cnt_reg <= '0;
        bad_cnt_reg  <= '0;
      end else if (rx_valid_i) begin
        hist_reg <= hist_next;
        case (state_reg)
          SEARCH_SEED: begin
            good_cnt_reg <= '0;
            state_reg    <= SEARCH;
          end
          SEARCH: begin
            if (err_any) begin
              good_cnt_reg <= '0;
            end else if (good_cnt_reg == GOOD_W'(LOCK_CNT - 1)) begin
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
              locked_reg   <= 1'b1;
              state_reg    <= LOCKED;
            end else begin
              good_cnt_reg <= good_cnt_reg + GOOD_W'(1);
            end
          end
          LOCKED: begin
            word_cnt_reg  <= word_cnt_next;
            bit_err_reg   <= bit_err_next;
            err_pulse_reg <= err_any;
            if (!err_any) begin
              bad_cnt_reg <= '0;
            end else if (bad_cnt_reg == BAD_W'(UNLOCK_CNT - 1)) begin
              bad_cnt_reg <= '0;
              locked_reg  <= 1'b0;
              state_reg   <= SEARCH_SEED;
            end else begin
              bad_cnt_reg <= bad_cnt_reg + BAD_W'(1);
            end
          end
          default: state_reg <= SEARCH_SEED;
        endcase
      end
      // Clear overrides any same-cycle count update.
      if (clr_i) begin
        bit_err_reg  <= '0;
        word_cnt_reg <= '0;
      end
    end
  end

  assign locked_o      = locked_reg;
  assign err_pulse_o   = err_pulse_reg;
  assign bit_err_cnt_o = bit_err_reg;
  assign word_cnt_o    = word_cnt_reg;

endmodule

// File: tb/tb_prbs_lock_check.sv
// Randomised bench for prbs_lock_check against a bit-serial PRBS reference stream.
// Define PRBS_LOCK_CHECK_INV_EN to also exercise the inverted-lane path.
module tb_prbs_lock_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0, data2 = '0;
  logic        valid = 1'b0, valid2 = 1'b0;
  logic [1:0]  sel = 2'd3, sel2 = 2'd2;
  logic        clr = 1'b0, clr2 = 1'b0;
  logic        inv = 1'b0, inv2 = 1'b0;
  logic        locked, err_pulse, locked2, err_pulse2;
  logic [31:0] bit_err, word_cnt;
  logic [3:0]  bit_err2, word_cnt2;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_err = '0;
  logic [31:0] exp_word = '0;

  // Reference generator: gen_q[k] holds bit b[n-1-k] relative to the next bit n.
  bit          gen_q[$];
  int          gen_n, gen_m;

  always #5 clk = ~clk;

  prbs_lock_check u_dut (
    .rx_user_clk_i (clk),
    .rx_user_rst_i (rst),
    .rx_data_i     (data),
    .rx_valid_i    (valid),
    .prbs_sel_i    (sel),
    .clr_i         (clr),
`ifdef PRBS_LOCK_CHECK_INV_EN
    .inv_i         (inv),
`endif
    .locked_o      (locked),
    .err_pulse_o   (err_pulse),
    .bit_err_cnt_o (bit_err),
    .word_cnt_o    (word_cnt)
  );

  prbs_lock_check #(.ERR_CNT_W(4)) u_dut_sat (
    .rx_user_clk_i (clk),
    .rx_user_rst_i (rst),
    .rx_data_i     (data2),
    .rx_valid_i    (valid2),
    .prbs_sel_i    (sel2),
    .clr_i         (clr2),
`ifdef PRBS_LOCK_CHECK_INV_EN
    .inv_i         (inv2),
`endif
    .locked_o      (locked2),
    .err_pulse_o   (err_pulse2),
    .bit_err_cnt_o (bit_err2),
    .word_cnt_o    (word_cnt2)
  );

  task automatic gen_seed(input int degree);
    case (degree)
      7:       begin gen_n = 7;  gen_m = 6;  end
      15:      begin gen_n = 15; gen_m = 14; end
      23:      begin gen_n = 23; gen_m = 18; end
      default: begin gen_n = 31; gen_m = 28; end
    endcase
    gen_q.delete();
    for (int i = 0; i < 31; i++) gen_q.push_back(bit'($urandom_range(0, 1)));
    gen_q[0] = 1'b1;
  endtask

  task automatic gen_word(output logic [31:0] w);
    bit nb;
    for (int i = 0; i < 32; i++) begin
      nb   = gen_q[gen_n-1] ^ gen_q[gen_m-1];
      w[i] = nb;
      gen_q.push_front(nb);
      void'(gen_q.pop_back());
    end
  endtask

  task automatic send(input logic [31:0] w, input bit tgt);
    if (tgt) begin data2 = w; valid2 = 1'b1; end
    else     begin data  = w; valid  = 1'b1; end
    @(posedge clk); #1;
    valid  = 1'b0;
    valid2 = 1'b0;
    $display("[TB] t=%0t dut=%0d word=%08h locked=%0b/%0b err=%0d/%0d words=%0d/%0d",
             $time, tgt, w, locked, locked2, bit_err, bit_err2, word_cnt, word_cnt2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic lock_stream(input bit tgt, input bit inv_data, input string tag);
    logic [31:0] w;
    logic        got;
    for (int k = 1; k <= 17; k++) begin
      gen_word(w);
      maybe_gap();
      send(inv_data ? ~w : w, tgt);
      got = tgt ? locked2 : locked;
      n_tests++;
      if (got !== (k == 17)) begin
        n_fail++;
        $display("FAIL %s_lock word %0d: locked=%0b expected %0b", tag, k, got, (k == 17));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_tests++;
    if ({locked, err_pulse, bit_err, word_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got l=%0b p=%0b e=%0d w=%0d expected all 0", locked, err_pulse, bit_err, word_cnt);
    end
    n_tests++;
    if ({locked2, err_pulse2, bit_err2, word_cnt2} !== '0) begin
      n_fail++;
      $display("FAIL reset_sat: got l=%0b p=%0b e=%0d w=%0d expected all 0", locked2, err_pulse2, bit_err2, word_cnt2);
    end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_lock_clean();
    logic [31:0] w;
    gen_seed(31);
    lock_stream(1'b0, 1'b0, "prbs31");
    for (int k = 0; k < 100; k++) begin
      gen_word(w);
      maybe_gap();
      send(w, 1'b0);
      exp_word++;
      n_tests++;
      if (err_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_pulse word %0d: got %0b expected 0", k, err_pulse);
      end
    end
    n_tests++;
    if (bit_err !== 32'd0) begin
      n_fail++;
      $display("FAIL clean_bit_err: got %0d expected 0", bit_err);
    end
    n_tests++;
    if (word_cnt !== 32'd100) begin
      n_fail++;
      $display("FAIL clean_word_cnt: got %0d expected 100", word_cnt);
    end
  endtask

  task automatic test_bit_errors();
    logic [31:0] w, mask;
    int p0, p1, p2;
    p0 = $urandom_range(0, 31);
    do p1 = $urandom_range(0, 31); while (p1 == p0);
    do p2 = $urandom_range(0, 31); while (p2 == p0 || p2 == p1);
    mask = '0;
    mask[p0] = 1'b1; mask[p1] = 1'b1; mask[p2] = 1'b1;
    gen_word(w);
    send(w ^ mask, 1'b0);
    exp_err += 3; exp_word++;
    n_tests++;
    if (err_pulse !== 1'b1 || bit_err !== exp_err || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL err3_word: got p=%0b e=%0d l=%0b expected p=1 e=%0d l=1", err_pulse, bit_err, locked, exp_err);
    end
    idle(1);
    n_tests++;
    if (err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL err3_pulse_width: got %0b expected 0", err_pulse);
    end
    gen_word(w);
    send(w, 1'b0);
    exp_word++;
    n_tests++;
    if (err_pulse !== 1'b0 || bit_err !== exp_err || word_cnt !== exp_word) begin
      n_fail++;
      $display("FAIL err3_next_clean: got p=%0b e=%0d w=%0d expected p=0 e=%0d w=%0d", err_pulse, bit_err, word_cnt, exp_err, exp_word);
    end
    for (int r = 0; r < 6; r++) begin
      mask = $urandom() | (32'd1 << $urandom_range(0, 31));
      gen_word(w);
      maybe_gap();
      send(w ^ mask, 1'b0);
      exp_err += 32'($countones(mask)); exp_word++;
      n_tests++;
      if (bit_err !== exp_err || err_pulse !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_err round %0d: got e=%0d p=%0b expected e=%0d p=1", r, bit_err, err_pulse, exp_err);
      end
      gen_word(w);
      send(w, 1'b0);
      exp_word++;
    end
    n_tests++;
    if (word_cnt !== exp_word || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_err_words: got w=%0d l=%0b expected w=%0d l=1", word_cnt, locked, exp_word);
    end
  endtask

  task automatic test_unlock();
    logic [31:0] w;
    for (int k = 1; k <= 8; k++) begin
      gen_word(w);
      exp_err += 32'($countones(w)); exp_word++;
      maybe_gap();
      send(32'd0, 1'b0);
      n_tests++;
      if (locked !== (k < 8)) begin
        n_fail++;
        $display("FAIL unlock word %0d: locked=%0b expected %0b", k, locked, (k < 8));
      end
    end
    n_tests++;
    if (bit_err !== exp_err || word_cnt !== exp_word) begin
      n_fail++;
      $display("FAIL unlock_counts: got e=%0d w=%0d expected e=%0d w=%0d", bit_err, word_cnt, exp_err, exp_word);
    end
  endtask

  task automatic test_poly_change();
    logic [31:0] w;
    lock_stream(1'b0, 1'b0, "relock31");
    sel = 2'd0;
    idle(1);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL poly_drop: locked=%0b expected 0", locked);
    end
    gen_seed(7);
    lock_stream(1'b0, 1'b0, "prbs7");
    n_tests++;
    if (bit_err !== exp_err || word_cnt !== exp_word) begin
      n_fail++;
      $display("FAIL poly_retain: got e=%0d w=%0d expected e=%0d w=%0d", bit_err, word_cnt, exp_err, exp_word);
    end
    for (int k = 0; k < 3; k++) begin
      gen_word(w);
      send(w, 1'b0);
      exp_word++;
    end
    n_tests++;
    if (bit_err !== exp_err || word_cnt !== exp_word) begin
      n_fail++;
      $display("FAIL prbs7_clean: got e=%0d w=%0d expected e=%0d w=%0d", bit_err, word_cnt, exp_err, exp_word);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    gen_word(w);
    send(w ^ 32'h0000_0100, 1'b0);
    n_tests++;
    if (err_pulse !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got p=%0b l=%0b expected p=1 l=1", err_pulse, locked);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({locked, err_pulse, bit_err, word_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got l=%0b p=%0b e=%0d w=%0d expected all 0", locked, err_pulse, bit_err, word_cnt);
    end
    idle(2);
    rst = 1'b0;
    idle(2);
    exp_err = '0; exp_word = '0;
    lock_stream(1'b0, 1'b0, "post_reset");
  endtask

`ifdef PRBS_LOCK_CHECK_INV_EN
  task automatic test_inverted();
    logic [31:0] w;
    sel = 2'd1;
    inv = 1'b1;
    idle(2);
    gen_seed(15);
    lock_stream(1'b0, 1'b1, "inv15");
    for (int k = 0; k < 20; k++) begin
      gen_word(w);
      send(~w, 1'b0);
      exp_word++;
    end
    n_tests++;
    if (bit_err !== exp_err || word_cnt !== exp_word) begin
      n_fail++;
      $display("FAIL inv15_counts: got e=%0d w=%0d expected e=%0d w=%0d", bit_err, word_cnt, exp_err, exp_word);
    end
    inv = 1'b0;
  endtask
`endif

  task automatic test_saturation();
    logic [31:0] w;
    int e2, w2;
    gen_seed(23);
    lock_stream(1'b1, 1'b0, "sat23");
    e2 = 0; w2 = 0;
    for (int k = 1; k <= 20; k++) begin
      gen_word(w);
      send(w ^ (32'd1 << $urandom_range(0, 31)), 1'b1);
      e2 = (e2 + 1 > 15) ? 15 : e2 + 1;
      w2 = (w2 + 1 > 15) ? 15 : w2 + 1;
      n_tests++;
      if (bit_err2 !== 4'(e2) || word_cnt2 !== 4'(w2) || err_pulse2 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_err %0d: got e=%0d w=%0d p=%0b expected e=%0d w=%0d p=1", k, bit_err2, word_cnt2, err_pulse2, e2, w2);
      end
      gen_word(w);
      send(w, 1'b1);
      w2 = (w2 + 1 > 15) ? 15 : w2 + 1;
    end
    gen_word(w);
    clr2 = 1'b1;
    send(w ^ 32'h8000_0000, 1'b1);
    clr2 = 1'b0;
    n_tests++;
    if (bit_err2 !== 4'd0 || word_cnt2 !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_clr_wins: got e=%0d w=%0d expected 0 0", bit_err2, word_cnt2);
    end
    gen_word(w);
    send(w ^ 32'h0000_0001, 1'b1);
    n_tests++;
    if (bit_err2 !== 4'd1 || word_cnt2 !== 4'd1 || locked2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_after_clr: got e=%0d w=%0d l=%0b expected 1 1 1", bit_err2, word_cnt2, locked2);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_clean();
    test_bit_errors();
    test_unlock();
    test_poly_change();
    test_reset_mid();
`ifdef PRBS_LOCK_CHECK_INV_EN
    test_inverted();
`endif
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
